// File: rtl/expr_seq_pkg.sv
// Shared types and constants for the expression vector sequencer.
// Optional comparator build switch: EXPR_SEQ_CMP_EN.
package expr_seq_pkg;

    localparam int OPW = 60;
    localparam int YW  = 90;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        DONE
    } state_t;

    // Feedback taps: LFSR bits 59,58; MISR bits 89..86.
    localparam logic [OPW-1:0] LFSR_TAPS = {2'b11, 58'd0};
    localparam logic [YW-1:0]  MISR_TAPS = {4'hF, 86'd0};

    // Operand fields a0..a5, b0..b5 in opnd_o, top bit first.
    localparam int FLD_N = 12;
    localparam int FLD_LSB [FLD_N] = '{56, 51, 45, 41, 36, 30,
                                       26, 21, 15, 11,  6,  0};
    localparam int FLD_W   [FLD_N] = '{ 4,  5,  6,  4,  5,  6,
                                        4,  5,  6,  4,  5,  6};

    function automatic logic [OPW-1:0] lfsr_step(
        input logic [OPW-1:0] s
    );
        return {s[OPW-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/expr_misr90.sv
// 90-bit multiple-input signature register.
// Clear has priority over the enabled capture.
module expr_misr90
    import expr_seq_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic [YW-1:0] y_i,
    output logic [YW-1:0] sig_o
);

    // Signature register: shift with tap feedback, fold in y_i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_o <= '0;
        end else if (clr) begin
            sig_o <= '0;
        end else if (en) begin
            sig_o <= {sig_o[YW-2:0], ^(sig_o & MISR_TAPS)} ^ y_i;
        end
    end

endmodule

// File: rtl/expr_vector_sequencer.sv
// LFSR stimulus / MISR capture sequencer for expression blocks.
// Optional result comparator build switch: EXPR_SEQ_CMP_EN.
module expr_vector_sequencer
    import expr_seq_pkg::*;
#(
    parameter int             NUM_VEC    = 256,
    parameter int             SETTLE_CYC = 1,
    parameter logic [OPW-1:0] SEED       = 60'h0123456789ABCDE,
    localparam int            VW = $clog2(NUM_VEC + 1),
    localparam int            CW = $clog2(SETTLE_CYC + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_i,
    input  logic           abort_i,
    input  logic [YW-1:0]  y_i,
`ifdef EXPR_SEQ_CMP_EN
    input  logic [YW-1:0]  exp_sig_i,
    output logic           pass_o,
    output logic           fail_o,
`endif
    output logic [OPW-1:0] opnd_o,
    output logic           busy_o,
    output logic           done_o,
    output logic [VW-1:0]  vec_idx_o,
    output logic [YW-1:0]  sig_o
);

    state_t         state;
    state_t         state_nxt;
    logic [OPW-1:0] lfsr;
    logic [CW-1:0]  cnt;
    logic           go;
    logic           cap;
    logic           last;

    assign last   = (vec_idx_o == VW'(NUM_VEC - 1));
    assign opnd_o = lfsr;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; abort beats capture so no MISR update on abort.
    always_comb begin
        state_nxt = state;
        go        = 1'b0;
        cap       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt = SETTLE;
                    go        = 1'b1;
                end
            end
            SETTLE: begin
                if (abort_i) begin
                    state_nxt = IDLE;
                end else if (cnt <= CW'(1)) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                if (abort_i) begin
                    state_nxt = IDLE;
                end else begin
                    cap       = 1'b1;
                    state_nxt = last ? DONE : SETTLE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand LFSR, vector index, settle counter, status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr      <= SEED;
            vec_idx_o <= '0;
            cnt       <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            busy_o <= (state_nxt != IDLE);
            done_o <= (state_nxt == DONE);
            if (go) begin
                lfsr      <= SEED;
                vec_idx_o <= '0;
                cnt       <= CW'(SETTLE_CYC);
            end else if (cap) begin
                lfsr      <= lfsr_step(lfsr);
                vec_idx_o <= vec_idx_o + VW'(1);
                cnt       <= CW'(SETTLE_CYC);
            end else if (state == SETTLE) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    expr_misr90 u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (go),
        .en    (cap),
        .y_i   (y_i),
        .sig_o (sig_o)
    );

`ifdef EXPR_SEQ_CMP_EN
    // Verdict latched in DONE; signature is stable there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_o <= 1'b0;
            fail_o <= 1'b0;
        end else if (go || (abort_i && state != IDLE)) begin
            pass_o <= 1'b0;
            fail_o <= 1'b0;
        end else if (state == DONE) begin
            pass_o <= (sig_o == exp_sig_i);
            fail_o <= (sig_o != exp_sig_i);
        end
    end
`endif

endmodule

// File: tb/tb_expr_vector_sequencer.sv
// Directed self-checking bench for expr_vector_sequencer.
// Three instances: (1 vec,1 settle), (2,1), (8,3).
module tb_expr_vector_sequencer;

    localparam logic [59:0] SEED    = 60'h0123456789ABCDE;
    localparam logic [59:0] SEED_NX = 60'h02468ACF13579BC;
    localparam logic [89:0] Y8      = {10'h2A5, 80'h0123456789ABCDEF0011};

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic s1 = 0, a1 = 0, b1, d1;
    logic [89:0] y1 = 90'h3FF, g1;
    logic [59:0] op1;
    logic [0:0]  v1;

    logic s2 = 0, a2 = 0, b2, d2;
    logic [89:0] y2 = 90'h1, g2;
    logic [59:0] op2;
    logic [1:0]  v2;

    logic s8 = 0, a8 = 0, b8, d8;
    logic [89:0] y8 = Y8, g8;
    logic [59:0] op8;
    logic [3:0]  v8;

`ifdef EXPR_SEQ_CMP_EN
    logic [89:0] e1 = '0, e2 = 90'h3, e8 = '0;
    logic p1, f1, p2, f2, p8, f8;
`endif

    int n_chk = 0;
    int n_fail = 0;
    logic [89:0] gold8;

    always #5 clk = ~clk;

    expr_vector_sequencer #(.NUM_VEC(1), .SETTLE_CYC(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start_i(s1), .abort_i(a1), .y_i(y1),
`ifdef EXPR_SEQ_CMP_EN
        .exp_sig_i(e1), .pass_o(p1), .fail_o(f1),
`endif
        .opnd_o(op1), .busy_o(b1), .done_o(d1),
        .vec_idx_o(v1), .sig_o(g1));

    expr_vector_sequencer #(.NUM_VEC(2), .SETTLE_CYC(1)) u2 (
        .clk(clk), .rst_n(rst_n), .start_i(s2), .abort_i(a2), .y_i(y2),
`ifdef EXPR_SEQ_CMP_EN
        .exp_sig_i(e2), .pass_o(p2), .fail_o(f2),
`endif
        .opnd_o(op2), .busy_o(b2), .done_o(d2),
        .vec_idx_o(v2), .sig_o(g2));

    expr_vector_sequencer #(.NUM_VEC(8), .SETTLE_CYC(3)) u8 (
        .clk(clk), .rst_n(rst_n), .start_i(s8), .abort_i(a8), .y_i(y8),
`ifdef EXPR_SEQ_CMP_EN
        .exp_sig_i(e8), .pass_o(p8), .fail_o(f8),
`endif
        .opnd_o(op8), .busy_o(b8), .done_o(d8),
        .vec_idx_o(v8), .sig_o(g8));

    function automatic logic [59:0] lfsr_nx(input logic [59:0] s);
        return {s[58:0], s[59] ^ s[58]};
    endfunction

    function automatic logic [89:0] misr_nx(input logic [89:0] m,
                                            input logic [89:0] y);
        return {m[88:0], m[89] ^ m[88] ^ m[87] ^ m[86]} ^ y;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        n_chk++;
        if (b1 !== 1'b0 || d1 !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_u1_flags: got busy=%b done=%b want 0 0", b1, d1);
        end
        n_chk++;
        if (op1 !== SEED || g1 !== 90'h0 || v1 !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_u1_regs: got op=%h sig=%h idx=%h", op1, g1, v1);
        end
        n_chk++;
        if (b8 !== 1'b0 || d8 !== 1'b0 || v8 !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_u8: got busy=%b done=%b idx=%0d", b8, d8, v8);
        end
        n_chk++;
        if (op8 !== SEED || g8 !== 90'h0) begin
            n_fail++;
            $display("FAIL rst_u8_regs: got op=%h sig=%h", op8, g8);
        end
    endtask

    task automatic test_single();
        s1 = 1'b1;
        tick();
        s1 = 1'b0;
        n_chk++;
        if (b1 !== 1'b1 || d1 !== 1'b0 || op1 !== SEED) begin
            n_fail++;
            $display("FAIL t1_c1: got busy=%b done=%b op=%h", b1, d1, op1);
        end
        tick();
        n_chk++;
        if (b1 !== 1'b1 || d1 !== 1'b0 || op1 !== SEED) begin
            n_fail++;
            $display("FAIL t1_c2: got busy=%b done=%b op=%h", b1, d1, op1);
        end
        tick();
        n_chk++;
        if (d1 !== 1'b1 || g1 !== 90'h3FF || v1 !== 1'b1) begin
            n_fail++;
            $display("FAIL t1_c3: got done=%b sig=%h idx=%h want 1 3ff 1", d1, g1, v1);
        end
        tick();
        n_chk++;
        if (d1 !== 1'b0 || b1 !== 1'b0 || g1 !== 90'h3FF) begin
            n_fail++;
            $display("FAIL t1_c4: got done=%b busy=%b sig=%h", d1, b1, g1);
        end
    endtask

    task automatic test_two_vec();
        logic [59:0] eop;
        s2 = 1'b1;
        tick();
        s2 = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c <= 4) begin
                eop = (c <= 2) ? SEED : SEED_NX;
                n_chk++;
                if (op2 !== eop) begin
                    n_fail++;
                    $display("FAIL t2_opnd c%0d: got %h want %h", c, op2, eop);
                end
            end
            n_chk++;
            if (d2 !== (c == 5)) begin
                n_fail++;
                $display("FAIL t2_done c%0d: got %b want %b", c, d2, (c == 5));
            end
            if (c < 6) tick();
        end
        n_chk++;
        if (g2 !== 90'h3 || v2 !== 2'd2 || b2 !== 1'b0) begin
            n_fail++;
            $display("FAIL t2_sig: got sig=%h idx=%0d busy=%b want 3 2 0", g2, v2, b2);
        end
    endtask

    task automatic test_long();
        logic [59:0] lf;
        int first;
        int nd;
        lf = SEED;
        first = 0;
        nd = 0;
        gold8 = '0;
        for (int k = 0; k < 8; k++) gold8 = misr_nx(gold8, Y8);
        s8 = 1'b1;
        tick();
        s8 = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1 && c <= 32 && (c - 1) % 4 == 0) lf = lfsr_nx(lf);
            if (c <= 32) begin
                n_chk++;
                if (op8 !== lf) begin
                    n_fail++;
                    $display("FAIL t3_opnd c%0d: got %h want %h", c, op8, lf);
                end
            end
            if (d8 === 1'b1) begin
                nd++;
                if (first == 0) first = c;
            end
            tick();
        end
        n_chk++;
        if (first != 33 || nd != 1) begin
            n_fail++;
            $display("FAIL t3_done: got cycle %0d count %0d want 33 1", first, nd);
        end
        n_chk++;
        if (v8 !== 4'd8 || g8 !== gold8) begin
            n_fail++;
            $display("FAIL t3_final: got idx=%0d sig=%h want 8 %h", v8, g8, gold8);
        end
    endtask

    task automatic test_busy_start();
        int first;
        first = 0;
        s8 = 1'b1;
        tick();
        s8 = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            s8 = (c == 5 || c == 20);
            if (d8 === 1'b1 && first == 0) first = c;
            tick();
        end
        s8 = 1'b0;
        n_chk++;
        if (first != 33 || g8 !== gold8 || b8 !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_start: got done@%0d sig=%h busy=%b", first, g8, b8);
        end
    endtask

    task automatic test_abort();
        logic [89:0] m2;
        logic [59:0] l2;
        int nd;
        int first;
        m2 = misr_nx(misr_nx(90'h0, Y8), Y8);
        l2 = lfsr_nx(lfsr_nx(SEED));
        nd = 0;
        s8 = 1'b1;
        tick();
        s8 = 1'b0;
        for (int c = 1; c < 9; c++) tick();
        a8 = 1'b1;
        tick();
        a8 = 1'b0;
        n_chk++;
        if (b8 !== 1'b0 || d8 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got busy=%b done=%b want 0 0", b8, d8);
        end
        n_chk++;
        if (v8 !== 4'd2 || g8 !== m2 || op8 !== l2) begin
            n_fail++;
            $display("FAIL abort_hold: got idx=%0d sig=%h op=%h", v8, g8, op8);
        end
        for (int c = 0; c < 20; c++) begin
            if (d8 === 1'b1) nd++;
            tick();
        end
        n_chk++;
        if (nd != 0 || g8 !== m2 || v8 !== 4'd2) begin
            n_fail++;
            $display("FAIL abort_frozen: got dones=%0d sig=%h idx=%0d", nd, g8, v8);
        end
        s8 = 1'b1;
        a8 = 1'b1;
        tick();
        s8 = 1'b0;
        a8 = 1'b0;
        n_chk++;
        if (b8 !== 1'b1) begin
            n_fail++;
            $display("FAIL start_abort_idle: got busy=%b want 1", b8);
        end
        first = 0;
        for (int c = 1; c <= 40 && first == 0; c++) begin
            if (d8 === 1'b1) first = c;
            else tick();
        end
        n_chk++;
        if (first != 33 || g8 !== gold8) begin
            n_fail++;
            $display("FAIL start_abort_run: got done@%0d sig=%h want 33 %h", first, g8, gold8);
        end
        tick();
    endtask

    task automatic test_reset_restart();
        int first;
        int nd;
        nd = 0;
        s8 = 1'b1;
        tick();
        s8 = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (b8 !== 1'b0 || d8 !== 1'b0 || v8 !== 4'd0) begin
            n_fail++;
            $display("FAIL async_rst_flags: got busy=%b done=%b idx=%0d", b8, d8, v8);
        end
        n_chk++;
        if (g8 !== 90'h0 || op8 !== SEED) begin
            n_fail++;
            $display("FAIL async_rst_regs: got sig=%h op=%h", g8, op8);
        end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (d8 === 1'b1) nd++;
            tick();
        end
        n_chk++;
        if (nd != 0 || b8 !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_done: got dones=%0d busy=%b", nd, b8);
        end
        s8 = 1'b1;
        tick();
        s8 = 1'b0;
        first = 0;
        for (int c = 1; c <= 40 && first == 0; c++) begin
            if (d8 === 1'b1) first = c;
            else tick();
        end
        n_chk++;
        if (first != 33 || g8 !== gold8) begin
            n_fail++;
            $display("FAIL rerun_sig: got done@%0d sig=%h want 33 %h", first, g8, gold8);
        end
        tick();
    endtask

`ifdef EXPR_SEQ_CMP_EN
    task automatic test_compare();
        e2 = 90'h3;
        s2 = 1'b1;
        tick();
        s2 = 1'b0;
        for (int c = 1; c < 6; c++) tick();
        n_chk++;
        if (p2 !== 1'b1 || f2 !== 1'b0) begin
            n_fail++;
            $display("FAIL cmp_pass: got pass=%b fail=%b want 1 0", p2, f2);
        end
        e2 = 90'h3 ^ (90'h1 << 40);
        s2 = 1'b1;
        tick();
        s2 = 1'b0;
        n_chk++;
        if (p2 !== 1'b0 || f2 !== 1'b0) begin
            n_fail++;
            $display("FAIL cmp_clear: got pass=%b fail=%b want 0 0", p2, f2);
        end
        for (int c = 1; c < 6; c++) tick();
        n_chk++;
        if (p2 !== 1'b0 || f2 !== 1'b1) begin
            n_fail++;
            $display("FAIL cmp_fail: got pass=%b fail=%b want 0 1", p2, f2);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_two_vec();
        test_long();
        test_busy_start();
        test_abort();
        test_reset_restart();
`ifdef EXPR_SEQ_CMP_EN
        test_compare();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
